// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the decode/fetch interlock.
// Register width, interlock states and stage destination bundle.
package hazard_unit_pkg;

  localparam int ADDR_LINE_REG = 5;

  localparam logic [31:0] NOP_INST = 32'h0;

  typedef enum logic [1:0] {
    RUN,
    STALL,
    FLUSH
  } hz_state_t;

  typedef struct packed {
    logic [ADDR_LINE_REG-1:0] dest;
    logic                     wr;
  } dst_t;

endpackage

// File: rtl/hazard_cmp.sv
// RAW comparator: decode sources vs. in-flight destinations.
// HAZARD_FWD_EN: only load-use on ID/EX requires a bubble.
module hazard_cmp
  import hazard_unit_pkg::*;
(
  input  logic                     id_valid,
  input  logic [ADDR_LINE_REG-1:0] rs,
  input  logic [ADDR_LINE_REG-1:0] rt,
  input  logic                     rt_used,
  input  dst_t                     id_d,
  input  dst_t                     ex_d,
  input  dst_t                     mem_d,
  input  logic                     mem_read,
  output logic [1:0]               need
);

  function automatic logic hit(
    input logic [ADDR_LINE_REG-1:0] src,
    input dst_t                     d
  );
    return d.wr && (d.dest == src) &&
           (d.dest != '0);
  endfunction

`ifdef HAZARD_FWD_EN
  logic unused_fwd;
  assign unused_fwd = ^{ex_d, mem_d};

  function automatic logic [1:0] need_of(
    input logic [ADDR_LINE_REG-1:0] src
  );
    return (hit(src, id_d) && mem_read) ?
           2'd1 : 2'd0;
  endfunction
`else
  logic unused_mem_read;
  assign unused_mem_read = mem_read;

  function automatic logic [1:0] need_of(
    input logic [ADDR_LINE_REG-1:0] src
  );
    logic [1:0] n;
    n = 2'd0;
    if (hit(src, id_d))
      n = 2'd3;
    else if (hit(src, ex_d))
      n = 2'd2;
    else if (hit(src, mem_d))
      n = 2'd1;
    return n;
  endfunction
`endif

  logic [1:0] n_rs;
  logic [1:0] n_rt;

  // worst case over both sources, nothing for empty decode slot
  always_comb begin
    n_rs = need_of(rs);
    n_rt = rt_used ? need_of(rt) : 2'd0;
    need = 2'd0;
    if (id_valid)
      need = (n_rs > n_rt) ? n_rs : n_rt;
  end

endmodule

// File: rtl/hazard_unit.sv
// Interlock controller: RAW stalls, branch flushes, perf counters.
// Optional macro HAZARD_FWD_EN: assume forwarding, stall on load-use only.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [ADDR_LINE_REG-1:0] rs_f_id,
  input  logic [ADDR_LINE_REG-1:0] rt_f_id,
  input  logic                     rt_used,
  input  logic [ADDR_LINE_REG-1:0] id_dest,
  input  logic                     reg_write_f_id,
  input  logic                     mem_read_f_id,
  input  logic [ADDR_LINE_REG-1:0] ex_dest,
  input  logic                     reg_write_f_ex,
  input  logic [ADDR_LINE_REG-1:0] mem_dest,
  input  logic                     reg_write_f_mem,
  input  logic                     branch_taken,
  output logic                     pc_hold,
  output logic                     bubble,
  output logic                     flush,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         flush_cnt
);

  localparam logic [1:0] FL_LOAD =
    2'(FLUSH_CYCLES - 1);
  localparam logic FL_STAY =
    (FLUSH_CYCLES > 1);

  hz_state_t  state;
  hz_state_t  nxt_state;
  logic [1:0] remain;
  logic [1:0] nxt_remain;
  logic [1:0] need;
  logic       st_inc;
  logic       fl_inc;
  dst_t       id_d;
  dst_t       ex_d;
  dst_t       mem_d;

  assign id_d  = '{dest: id_dest,
                   wr:   reg_write_f_id};
  assign ex_d  = '{dest: ex_dest,
                   wr:   reg_write_f_ex};
  assign mem_d = '{dest: mem_dest,
                   wr:   reg_write_f_mem};

  hazard_cmp u_cmp (
    .id_valid (id_valid),
    .rs       (rs_f_id),
    .rt       (rt_f_id),
    .rt_used  (rt_used),
    .id_d     (id_d),
    .ex_d     (ex_d),
    .mem_d    (mem_d),
    .mem_read (mem_read_f_id),
    .need     (need)
  );

  // state and countdown registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= RUN;
      remain <= 2'd0;
    end else begin
      state  <= nxt_state;
      remain <= nxt_remain;
    end
  end

  // next state and Mealy controls; branch beats any hazard
  always_comb begin
    nxt_state  = state;
    nxt_remain = remain;
    pc_hold    = 1'b0;
    bubble     = 1'b0;
    flush      = 1'b0;
    st_inc     = 1'b0;
    fl_inc     = 1'b0;
    if (branch_taken) begin
      flush      = 1'b1;
      bubble     = 1'b1;
      fl_inc     = 1'b1;
      nxt_state  = FL_STAY ? FLUSH : RUN;
      nxt_remain = FL_LOAD;
    end else begin
      unique case (1'b1)
        (state == RUN): begin
          if (need != 2'd0) begin
            pc_hold    = 1'b1;
            bubble     = 1'b1;
            st_inc     = 1'b1;
            nxt_remain = need - 2'd1;
            if (need > 2'd1)
              nxt_state = STALL;
          end
        end
        (state == STALL): begin
          pc_hold    = 1'b1;
          bubble     = 1'b1;
          st_inc     = 1'b1;
          nxt_remain = remain - 2'd1;
          if (remain <= 2'd1)
            nxt_state = RUN;
        end
        (state == FLUSH): begin
          flush      = 1'b1;
          bubble     = 1'b1;
          nxt_remain = remain - 2'd1;
          if (remain <= 2'd1)
            nxt_state = RUN;
        end
        default: begin
          nxt_state  = RUN;
          nxt_remain = 2'd0;
        end
      endcase
    end
    if (reset) begin
      pc_hold = 1'b0;
      bubble  = 1'b0;
      flush   = 1'b0;
    end
  end

  // saturating event counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (st_inc && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (fl_inc && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
